cpu_peripheral_bridge: RTL

//  Single-clock, parametrised CPU-to-peripheral bus bridge for the clk_2x peripheral domain.

---
 rtl/cpu_peripheral_bridge_pkg.sv | 18 +
 rtl/cpu_peripheral_bridge_if.sv | 23 ++
 rtl/cpu_peripheral_bridge_timeout_counter.sv | 40 ++++
 rtl/cpu_peripheral_bridge.sv | 135 +++++++++++++
 4 files changed

// File: rtl/cpu_peripheral_bridge_pkg.sv
// Shared types for the CPU-to-peripheral bridge:
// FSM encoding, default error data, counter sizing.
package cpu_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RESPOND = 2'd3
  } bridge_state_t;

  localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int ctr_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cpu_peripheral_bridge_if.sv
// Request/response bus shared by the CPU side
// and the peripheral side of the bridge.
interface cpu_peripheral_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    mem_valid;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    mem_ready;
  logic [DATA_WIDTH-1:0]   read_data;

  modport master (
    output mem_valid, address, wstrb, write_data,
    input  mem_ready, read_data
  );

  modport slave (
    input  mem_valid, address, wstrb, write_data,
    output mem_ready, read_data
  );
endinterface

// File: rtl/cpu_peripheral_bridge_timeout_counter.sv
// Saturating WAIT-cycle counter; expired marks the
// edge on which the count reaches TIMEOUT_CYCLES.
module bridge_timeout_counter
  import cpu_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_2x,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = ctr_width(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = &{1'b0, clk_2x, reset, clear, enable};
    assign expired   = 1'b0;
  end else begin : g_on
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_2x or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (enable && cnt_q != TOP) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign expired = enable && (cnt_q == LAST);
  end

endmodule

// File: rtl/cpu_peripheral_bridge.sv
// CPU-to-peripheral bridge: registered request, one ready
// pulse per transaction, abort, timeout with sticky error.
module cpu_peripheral_bridge
  import cpu_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          RSP_STAGES     = 1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEFAULT
) (
  input  logic                    clk_2x,
  input  logic                    reset,
  cpu_peripheral_bridge_if.slave  cpu,
  cpu_peripheral_bridge_if.master periph,
  output logic                    bus_error,
  input  logic                    error_clear
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] ERR_D = DATA_WIDTH'(ERROR_DATA);

  if (RSP_STAGES < 1 || RSP_STAGES > 2 || (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
    $fatal(1, "cpu_peripheral_bridge: RSP_STAGES must be 1..2, DATA_WIDTH a multiple of 8");
  end

  bridge_state_t         state_q;
  bridge_state_t         state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SW-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rsp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  tmo_exp;
  logic                  in_wait;
  logic                  take_rsp;
  logic                  take_tmo;
  logic                  cpu_ready;
  logic                  periph_valid;

  assign in_wait  = (state_q == ST_WAIT);
  assign take_rsp = in_wait && cpu.mem_valid && periph.mem_ready;
  assign take_tmo = in_wait && cpu.mem_valid && !periph.mem_ready && tmo_exp;

  bridge_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_2x (clk_2x),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk_2x or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu.mem_valid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cpu.mem_valid) begin
          state_d = ST_IDLE;
        end else if (periph.mem_ready) begin
          state_d = (RSP_STAGES == 2) ? ST_DRAIN : ST_RESPOND;
        end else if (tmo_exp) begin
          state_d = ST_RESPOND;
        end
      end
      ST_DRAIN: begin
        state_d = cpu.mem_valid ? ST_RESPOND : ST_IDLE;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready    = 1'b0;
    periph_valid = 1'b0;
    unique case (1'b1)
      (state_q == ST_WAIT):    periph_valid = 1'b1;
      (state_q == ST_RESPOND): cpu_ready    = 1'b1;
      default: ;
    endcase
  end

  // rdata_q only moves when a response is committed, so an
  // abort in DRAIN leaves the CPU-visible data untouched.
  always_ff @(posedge clk_2x or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rsp_q     <= '0;
      rdata_q   <= '0;
      bus_error <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && cpu.mem_valid) begin
        addr_q  <= cpu.address;
        strb_q  <= cpu.wstrb;
        wdata_q <= cpu.write_data;
      end
      if (take_rsp) begin
        rsp_q <= periph.read_data;
        if (RSP_STAGES == 1) rdata_q <= periph.read_data;
      end
      if (take_tmo) rdata_q <= ERR_D;
      if (state_q == ST_DRAIN && cpu.mem_valid) rdata_q <= rsp_q;
      if (take_tmo) begin
        bus_error <= 1'b1;
      end else if (error_clear) begin
        bus_error <= 1'b0;
      end
    end
  end

  assign cpu.mem_ready     = cpu_ready;
  assign cpu.read_data     = rdata_q;
  assign periph.mem_valid  = periph_valid;
  assign periph.address    = addr_q;
  assign periph.wstrb      = strb_q;
  assign periph.write_data = wdata_q;

endmodule
